// File: rtl/hdb3_rx_checker.sv
// HDB3 receive side: dual-rail symbol decode, line-code checks and a
// self-synchronising PRBS bit-error monitor on the recovered NRZ stream.
module hdb3_rx_checker #(
    parameter int                  PRBS_LEN  = 7,
    parameter logic [PRBS_LEN-1:0] PRBS_TAPS = 7'b1100000,
    parameter int                  LOSS_THR  = 4,
    parameter int                  CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_en,
    input  logic             bp,
    input  logic             bn,
    input  logic             clr_cnt,
    output logic             data_out,
    output logic             data_vld,
    output logic             code_err,
    output logic             lock,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int HC_W = $clog2(PRBS_LEN);
    localparam int MS_W = $clog2(LOSS_THR + 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    logic       seen_mark_q;
    logic       last_pol_q;
    logic       seen_v_q;
    logic       last_vpol_q;
    logic [1:0] zrun_q, zrun_d;
    logic [3:0] sr_q, sr_d;
    logic [2:0] fill_q;
    logic       dout_q;
    logic       vld_q;
    logic       cerr_q;

    logic mark;
    logic illegal;
    logic is_v;
    logic zero_err;
    logic vpol_err;
    logic primed;

    assign mark     = bp ^ bn;
    assign illegal  = bp & bn;
    assign is_v     = mark & seen_mark_q & (bp == last_pol_q);
    assign vpol_err = is_v & seen_v_q & (bp == last_vpol_q);
    assign primed   = (fill_q == 3'd4);

    always_comb begin
        zrun_d   = zrun_q;
        zero_err = 1'b0;
        if (mark) begin
            zrun_d = 2'd0;
        end else if (zrun_q == 2'd3) begin
            zrun_d   = 2'd0;
            zero_err = 1'b1;
        end else begin
            zrun_d = zrun_q + 2'd1;
        end
    end

    // A V mark clears the slot three symbols back: the B pulse or the
    // leading zero of a 000V group.
    assign sr_d = {is_v ? 1'b0 : sr_q[2], sr_q[1:0], mark & ~is_v};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_mark_q <= 1'b0;
            last_pol_q  <= 1'b0;
            seen_v_q    <= 1'b0;
            last_vpol_q <= 1'b0;
            zrun_q      <= 2'd0;
            sr_q        <= 4'd0;
            fill_q      <= 3'd0;
            dout_q      <= 1'b0;
            vld_q       <= 1'b0;
            cerr_q      <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            cerr_q <= 1'b0;
            if (sym_en) begin
                vld_q  <= primed;
                cerr_q <= illegal | zero_err | vpol_err;
                dout_q <= sr_q[3];
                sr_q   <= sr_d;
                zrun_q <= zrun_d;
                if (!primed) begin
                    fill_q <= fill_q + 3'd1;
                end
                if (mark) begin
                    seen_mark_q <= 1'b1;
                    last_pol_q  <= bp;
                end
                if (is_v) begin
                    seen_v_q    <= 1'b1;
                    last_vpol_q <= bp;
                end
            end
        end
    end

    assign data_out = dout_q;
    assign data_vld = vld_q;
    assign code_err = cerr_q;

    state_e              state_q, state_d;
    logic [PRBS_LEN-1:0] lfsr_q, lfsr_d, lfsr_ld;
    logic [HC_W-1:0]     hcnt_q, hcnt_d;
    logic [MS_W-1:0]     miss_q, miss_d, miss_inc;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    bit_q, bit_d;

    logic bit_vld;
    logic bit_in;
    logic exp_bit;
    logic mism;
    logic load_done;
    logic lost;
    logic chk_en;

    // The checker consumes the bit being launched onto data_out this edge.
    assign bit_vld   = sym_en & primed;
    assign bit_in    = sr_q[3];
    assign exp_bit   = ^(lfsr_q & PRBS_TAPS);
    assign mism      = bit_in ^ exp_bit;
    assign lfsr_ld   = {lfsr_q[PRBS_LEN-2:0], bit_in};
    assign miss_inc  = miss_q + 1'b1;
    assign load_done = (hcnt_q == HC_W'(PRBS_LEN - 1));
    assign lost      = mism & (miss_inc == MS_W'(LOSS_THR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            lfsr_q  <= '0;
            hcnt_q  <= '0;
            miss_q  <= '0;
            err_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            hcnt_q  <= hcnt_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_vld) begin
            unique case (state_q)
                HUNT: begin
                    if (load_done && (lfsr_ld != '0)) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (lost) begin
                        state_d = HUNT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        lock   = (state_q == LOCK);
        chk_en = bit_vld & (state_q == LOCK);
    end

    // In LOCK the register free-runs on its own prediction.
    always_comb begin
        lfsr_d = lfsr_q;
        hcnt_d = hcnt_q;
        miss_d = miss_q;
        if (bit_vld) begin
            unique case (state_q)
                HUNT: begin
                    lfsr_d = lfsr_ld;
                    hcnt_d = load_done ? '0 : hcnt_q + 1'b1;
                end
                LOCK: begin
                    lfsr_d = {lfsr_q[PRBS_LEN-2:0], exp_bit};
                    miss_d = mism ? miss_inc : '0;
                    if (lost) begin
                        lfsr_d = '0;
                        miss_d = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        bit_d = bit_q;
        if (chk_en) begin
            if (bit_q != '1) begin
                bit_d = bit_q + 1'b1;
            end
            if (mism && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end
        if (clr_cnt) begin
            err_d = '0;
            bit_d = '0;
        end
    end

    assign err_cnt = err_q;
    assign bit_cnt = bit_q;

endmodule

// File: tb/tb_hdb3_rx_checker.sv
// Scoreboard bench for hdb3_rx_checker: an HDB3 encoder feeds the DUT and
// a rule-level model predicts decode, code errors and PRBS checker state.
module tb_hdb3_rx_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sym_en = 1'b0;
    logic        bp = 1'b0;
    logic        bn = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        data_out, data_vld, code_err, lock;
    logic [15:0] err_cnt, bit_cnt;

    always #5 clk = ~clk;

    hdb3_rx_checker dut (
        .clk      (clk),
        .rst      (rst),
        .sym_en   (sym_en),
        .bp       (bp),
        .bn       (bn),
        .data_out (data_out),
        .data_vld (data_vld),
        .code_err (code_err),
        .lock     (lock),
        .err_cnt  (err_cnt),
        .bit_cnt  (bit_cnt),
        .clr_cnt  (clr_cnt)
    );

    typedef struct {
        bit vld;
        bit dat;
        bit err;
        bit lck;
        int ec;
        int bc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   got_q[$];
    int   err_pulses = 0;
    bit   armed = 0;

    bit src[$];
    bit sp[$];
    bit sn[$];

    bit m_seen, m_pol, m_seenv, m_vpol;
    int m_zrun;
    bit m_dec[$];
    bit m_hunt;
    bit m_win[$];
    bit m_ref[$];
    int m_miss, m_ec, m_bc;

    function automatic void check(string nm, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, got, want, $time);
        end
    endfunction

    function automatic void model_reset();
        m_seen = 0; m_pol = 0; m_seenv = 0; m_vpol = 0; m_zrun = 0;
        m_dec.delete();
        m_hunt = 1; m_win.delete(); m_ref.delete();
        m_miss = 0; m_ec = 0; m_bc = 0;
    endfunction

    function automatic void prbs_step(bit b);
        bit e;
        int ones;
        if (m_hunt) begin
            m_win.push_back(b);
            if (m_win.size() == 7) begin
                ones = 0;
                foreach (m_win[i]) ones += int'(m_win[i]);
                if (ones != 0) begin
                    m_hunt = 0;
                    m_ref  = m_win;
                    m_miss = 0;
                end
                m_win.delete();
            end
        end else begin
            // x^7 + x^6 + 1: next = bit seven back XOR bit six back
            e = m_ref[0] ^ m_ref[1];
            void'(m_ref.pop_front());
            m_ref.push_back(e);
            if (m_bc < 65535) m_bc++;
            if (b != e) begin
                if (m_ec < 65535) m_ec++;
                m_miss++;
                if (m_miss == 4) begin
                    m_hunt = 1;
                    m_miss = 0;
                    m_win.delete();
                end
            end else begin
                m_miss = 0;
            end
        end
    endfunction

    function automatic void model_step(bit p, bit n, bit clr);
        exp_t e;
        bit mark = p ^ n;
        bit v = mark && m_seen && (p == m_pol);
        bit b;
        e.err = p & n;
        if (!mark) begin
            m_zrun++;
            if (m_zrun == 4) begin
                e.err  = 1;
                m_zrun = 0;
            end
        end else begin
            m_zrun = 0;
        end
        if (v) begin
            if (m_seenv && (p == m_vpol)) e.err = 1;
            m_seenv = 1;
            m_vpol  = p;
        end
        if (mark) begin
            m_seen = 1;
            m_pol  = p;
        end
        m_dec.push_back(mark && !v);
        if (v && (m_dec.size() >= 4)) m_dec[m_dec.size() - 4] = 0;
        e.vld = 0;
        e.dat = 0;
        if (m_dec.size() == 5) begin
            b = m_dec.pop_front();
            e.vld = 1;
            e.dat = b;
            prbs_step(b);
        end
        if (clr) begin
            m_ec = 0;
            m_bc = 0;
        end
        e.lck = !m_hunt;
        e.ec  = m_ec;
        e.bc  = m_bc;
        exp_q.push_back(e);
    endfunction

    function automatic void encode();
        int last = -1;
        int ones = 0;
        int zeros = 0;
        int s[$];
        foreach (src[i]) begin
            if (src[i]) begin
                last = -last;
                s.push_back(last);
                ones++;
                zeros = 0;
            end else begin
                zeros++;
                s.push_back(0);
                if (zeros == 4) begin
                    if (ones % 2 == 1) begin
                        s[i] = last;
                    end else begin
                        last = -last;
                        s[i - 3] = last;
                        s[i] = last;
                    end
                    ones = 0;
                    zeros = 0;
                end
            end
        end
        sp.delete();
        sn.delete();
        foreach (s[i]) begin
            sp.push_back(s[i] > 0);
            sn.push_back(s[i] < 0);
        end
    endfunction

    function automatic void gen_prbs(int len);
        int seed = $urandom_range(1, 127);
        src.delete();
        for (int i = 0; i < 7; i++) src.push_back(seed[i]);
        for (int i = 7; i < len; i++) src.push_back(src[i - 7] ^ src[i - 6]);
    endfunction

    function automatic int got_bits(int k);
        int r = 0;
        for (int i = 0; i < k && i < got_q.size(); i++) r = (r << 1) | int'(got_q[i]);
        return r;
    endfunction

    task automatic strobe(input bit p, input bit n, input bit clr);
        @(negedge clk);
        bp = p;
        bn = n;
        sym_en = 1'b1;
        clr_cnt = clr;
        model_step(p, n, clr);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            sym_en = 1'b0;
            clr_cnt = 1'b0;
            bp = 1'b0;
            bn = 1'b0;
        end
    endtask

    task automatic send(input int from, input int to);
        for (int i = from; i < to; i++) begin
            strobe(sp[i], sn[i], 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
    endtask

    task automatic do_reset();
        sym_en = 1'b0;
        clr_cnt = 1'b0;
        bp = 1'b0;
        bn = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_lock", lock, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_data_vld", data_vld, 0);
        check("rst_data_out", data_out, 0);
        check("rst_code_err", code_err, 0);
        exp_q.delete();
        model_reset();
        armed = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        bit   en_s;
        exp_t e;
        forever begin
            @(posedge clk);
            en_s = sym_en & ~rst;
            @(negedge clk);
            if (armed && !rst) begin
                if (en_s) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_vld", data_vld, e.vld);
                        if (e.vld) check("data_out", data_out, e.dat);
                        check("code_err", code_err, e.err);
                        check("lock", lock, e.lck);
                        check("err_cnt", err_cnt, e.ec);
                        check("bit_cnt", bit_cnt, e.bc);
                    end
                    if (data_vld) got_q.push_back(data_out);
                    if (code_err) err_pulses++;
                end else begin
                    check("idle_vld", data_vld, 0);
                    check("idle_code_err", code_err, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int r;
        model_reset();

        do_reset();
        got_q.delete(); err_pulses = 0;
        for (int i = 0; i < 20; i++) strobe(1'b0, 1'b0, 1'b0);
        idle(2);
        check("zeros_err_pulses", err_pulses, 5);
        check("zeros_vld_count", got_q.size(), 16);
        check("zeros_lock", lock, 0);

        do_reset();
        src = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        encode();
        got_q.delete(); err_pulses = 0;
        send(0, 10);
        check("v000_bits", got_bits(6), 6'b100001);
        check("v000_count", got_q.size(), 6);
        check("v000_err", err_pulses, 0);

        do_reset();
        src = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        encode();
        got_q.delete(); err_pulses = 0;
        send(0, 10);
        check("b00v_bits", got_bits(6), 6'b110000);
        check("b00v_err", err_pulses, 0);

        do_reset();
        sp = '{1, 0, 1, 1, 0, 1, 0, 1, 0};
        sn = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
        got_q.delete(); err_pulses = 0;
        send(0, 9);
        check("illegal_bits", got_bits(5), 5'b11011);
        check("illegal_err", err_pulses, 1);

        do_reset();
        gen_prbs(300);
        src[220] = ~src[220];
        for (int i = 280; i < 284; i++) src[i] = ~src[i];
        encode();
        send(0, 10);
        check("prbs_prelock", lock, 0);
        send(10, 11);
        check("prbs_lock", lock, 1);
        send(11, 200);
        check("prbs_bits189", bit_cnt, 189);
        check("prbs_clean_err", err_cnt, 0);
        send(200, 260);
        check("prbs_one_err", err_cnt, 1);
        check("prbs_hold_lock", lock, 1);
        send(260, 288);
        check("prbs_loss", lock, 0);
        check("prbs_loss_err", err_cnt, 5);
        send(288, 295);
        check("prbs_relock", lock, 1);
        send(295, 300);

        do_reset();
        gen_prbs(60);
        src[20] = ~src[20]; src[25] = ~src[25]; src[30] = ~src[30];
        encode();
        send(0, 40);
        check("pre_rst_err3", err_cnt, 3);
        check("pre_rst_lock", lock, 1);
        do_reset();
        gen_prbs(60);
        src[20] = ~src[20]; src[30] = ~src[30];
        encode();
        send(0, 34);
        check("pre_clr_err", err_cnt, 1);
        strobe(sp[34], sn[34], 1'b1);
        idle(2);
        check("clr_err", err_cnt, 0);
        check("clr_bits", bit_cnt, 0);
        check("clr_lock", lock, 1);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) strobe(1'b1, 1'b1, 1'b0);
            else if (r < 6) strobe(1'b0, 1'b0, $urandom_range(0, 31) == 0);
            else begin
                bit p = $urandom_range(0, 1);
                strobe(p, ~p, $urandom_range(0, 31) == 0);
            end
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
